// File: rtl/xbar_write_order_scheduler.sv
// rtl/xbar_write_order_scheduler.sv - per-slave W-channel sequencer, bursts forwarded in AW acceptance order
// Optional length-driven burst termination with WLAST checking: define XBAR_WLAST_CHECK_EN.
module xbar_write_order_scheduler #(
  parameter int masters       = 2,
  parameter int pending_depth = 8,
  parameter int LEN_WIDTH     = 4,
  localparam int MW = (masters > 1) ? $clog2(masters) : 1,
  localparam int AW = $clog2(pending_depth)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 aw_push,
  input  logic [MW-1:0]        aw_master,
  input  logic [LEN_WIDTH-1:0] aw_len,
  output logic                 aw_block,
  input  logic                 w_src_valid,
  input  logic                 w_src_last,
  input  logic                 slave_w_fifo_full,
  output logic [MW-1:0]        write_data_forward_src_master,
  output logic                 w_push,
  output logic                 order_empty,
  output logic [AW:0]          order_count,
  output logic                 wlast_error
);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [MW-1:0] mst_mem_q [pending_depth];
  logic          burst_end;
  logic          push_ok;

  assign order_count = wptr_q - rptr_q;
  assign order_empty = (order_count == '0);
  assign aw_block    = (order_count == (AW+1)'(pending_depth));
  assign w_push      = ~order_empty & w_src_valid & ~slave_w_fifo_full;
  assign write_data_forward_src_master = order_empty ? '0 : mst_mem_q[rptr_q[AW-1:0]];

  // A pop in the same edge frees the slot, so a push is accepted even when full.
  assign push_ok = aw_push & (~aw_block | burst_end);
  assign wptr_d  = push_ok   ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d  = burst_end ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mst_mem_q[wptr_q[AW-1:0]] <= aw_master;
  end

`ifdef XBAR_WLAST_CHECK_EN
  logic [LEN_WIDTH-1:0] len_mem_q [pending_depth];
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 wlast_error_q, wlast_error_d;
  logic                 len_hit;

  assign len_hit       = (beat_cnt_q == len_mem_q[rptr_q[AW-1:0]]);
  assign burst_end     = w_push & len_hit;
  assign beat_cnt_d    = burst_end ? '0 : (w_push ? beat_cnt_q + 1'b1 : beat_cnt_q);
  assign wlast_error_d = w_push & (w_src_last != len_hit);
  assign wlast_error   = wlast_error_q;

  always_ff @(posedge ACLK) begin
    if (push_ok) len_mem_q[wptr_q[AW-1:0]] <= aw_len;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      beat_cnt_q    <= '0;
      wlast_error_q <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      wlast_error_q <= wlast_error_d;
    end
  end
`else
  logic unused_len;

  assign unused_len  = ^aw_len;
  assign burst_end   = w_push & w_src_last;
  assign wlast_error = 1'b0;
`endif

endmodule
